// File: rtl/uart_receiver.sv
// uart_receiver
//   Receives 8E1 serial frames: a start bit, 8 data bits LSB first, an even
//   parity bit and a stop bit. Reception is timed by a 16x oversampling tick
//   derived from CLK_HZ and a baud rate code. Every line decision is taken at
//   the bit centre, on the synchronized copy of RxD.
//
//   Ports
//     clk          system clock; all logic runs on its rising edge
//     reset        synchronous, active-low reset
//     Rx_EN        receiver enable; while low the receiver sits in IDLE
//     baud_select  000=300 001=1200 010=4800 011=9600 100=19200
//                  101=38400 110=57600 111=115200 baud
//     RxD          serial line, idle high, asynchronous to clk
//     Rx_DATA      last received byte, loaded even when the frame had errors
//     Rx_VALID     one-cycle pulse for each frame received without errors
//     Rx_PERROR    parity error of the last frame
//     Rx_FERROR    framing error (stop bit low) of the last frame
//
//   state  | meaning
//   IDLE   | waiting for a falling edge on RxD
//   START  | confirming the start bit at its centre (tick 7)
//   DATA   | sampling 8 data bits, one every 16 ticks
//   PARITY | sampling the parity bit and checking it
//   STOP   | sampling the stop bit and publishing data and flags
module uart_receiver #(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Rx_EN,
  input  logic [2:0] baud_select,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  // Rounded divide: round(CLK_HZ / (16 * baud)).
  function automatic int unsigned div_for(input int unsigned baud);
    return (CLK_HZ + 8 * baud) / (16 * baud);
  endfunction

  localparam int unsigned DIV_300    = div_for(300);
  localparam int unsigned DIV_1200   = div_for(1200);
  localparam int unsigned DIV_4800   = div_for(4800);
  localparam int unsigned DIV_9600   = div_for(9600);
  localparam int unsigned DIV_19200  = div_for(19200);
  localparam int unsigned DIV_38400  = div_for(38400);
  localparam int unsigned DIV_57600  = div_for(57600);
  localparam int unsigned DIV_115200 = div_for(115200);
  localparam int          CW         = $clog2(DIV_300 + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q, rxd_prev_q;
  logic [2:0]      baud_q;
  logic [CW-1:0]   div_cnt_q, div_cnt_d;
  logic [CW-1:0]   div_sel;
  logic            tick;
  logic [3:0]      tick_cnt_q, tick_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            perr_q, perr_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            perr_flag_q, perr_flag_d;
  logic            ferr_q, ferr_d;
  logic            rxd_s, rxd_fall;

  assign rxd_s    = sync2_q;
  assign rxd_fall = rxd_prev_q & ~sync2_q;

  always_comb begin
    div_sel = CW'(DIV_300);
    case (baud_select)
      3'd0: div_sel = CW'(DIV_300);
      3'd1: div_sel = CW'(DIV_1200);
      3'd2: div_sel = CW'(DIV_4800);
      3'd3: div_sel = CW'(DIV_9600);
      3'd4: div_sel = CW'(DIV_19200);
      3'd5: div_sel = CW'(DIV_38400);
      3'd6: div_sel = CW'(DIV_57600);
      3'd7: div_sel = CW'(DIV_115200);
      default: div_sel = CW'(DIV_300);
    endcase
  end

  // A rate change restarts the divider so the first tick at the new rate
  // comes a full period later.
  always_comb begin
    tick      = 1'b0;
    div_cnt_d = div_cnt_q + CW'(1);
    if (baud_select != baud_q) begin
      div_cnt_d = '0;
    end else if (div_cnt_q == div_sel - CW'(1)) begin
      tick      = 1'b1;
      div_cnt_d = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    perr_d      = perr_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    perr_flag_d = perr_flag_q;
    ferr_d      = ferr_q;
    if (tick && state_q != IDLE) tick_cnt_d = tick_cnt_q + 4'd1;
    case (state_q)
      IDLE: begin
        if (Rx_EN && rxd_fall) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end
      START: begin
        if (tick && tick_cnt_q == 4'd7) begin
          if (!rxd_s) begin
            state_d     = DATA;
            tick_cnt_d  = '0;
            bit_idx_d   = '0;
            perr_flag_d = 1'b0;
            ferr_d      = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick && tick_cnt_q == 4'd15) begin
          shift_d = {rxd_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = PARITY;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      PARITY: begin
        if (tick && tick_cnt_q == 4'd15) begin
          perr_d  = rxd_s ^ (^shift_q);
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick && tick_cnt_q == 4'd15) begin
          data_d      = shift_q;
          perr_flag_d = perr_q;
          ferr_d      = ~rxd_s;
          valid_d     = ~perr_q & rxd_s;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!Rx_EN) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rxd_prev_q  <= 1'b1;
      baud_q      <= baud_select;
      div_cnt_q   <= '0;
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      perr_q      <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_flag_q <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      sync1_q     <= RxD;
      sync2_q     <= sync1_q;
      rxd_prev_q  <= sync2_q;
      baud_q      <= baud_select;
      div_cnt_q   <= div_cnt_d;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      perr_q      <= perr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_flag_q <= perr_flag_d;
      ferr_q      <= ferr_d;
    end
  end

  assign Rx_DATA   = data_q;
  assign Rx_VALID  = valid_q;
  assign Rx_PERROR = perr_flag_q;
  assign Rx_FERROR = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver. Instance A runs at 50 MHz / 115200 baud (DIV=27).
// Instance B runs on a 5 MHz parameterisation at 9600 baud (DIV=33), which
// keeps the back-to-back low-rate case short.
module tb_uart_receiver;

  localparam int BT_A = 16 * 27;
  localparam int BT_B = 16 * 33;

  logic       clk = 1'b0;
  logic       reset;
  logic       Rx_EN;
  logic [2:0] baud_a, baud_b;
  logic       rxd_a, rxd_b;
  logic [7:0] data_a, data_b;
  logic       val_a, val_b, perr_a, perr_b, ferr_a, ferr_b;

  int n_checks = 0;
  int n_fail   = 0;
  int vcnt_a   = 0;
  int vcnt_b   = 0;
  int exp_cnt_a = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  always #10 clk = ~clk;

  uart_receiver uA (
    .clk(clk), .reset(reset), .Rx_EN(Rx_EN), .baud_select(baud_a), .RxD(rxd_a),
    .Rx_DATA(data_a), .Rx_VALID(val_a), .Rx_PERROR(perr_a), .Rx_FERROR(ferr_a)
  );

  uart_receiver #(.CLK_HZ(5000000)) uB (
    .clk(clk), .reset(reset), .Rx_EN(Rx_EN), .baud_select(baud_b), .RxD(rxd_b),
    .Rx_DATA(data_b), .Rx_VALID(val_b), .Rx_PERROR(perr_b), .Rx_FERROR(ferr_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every Rx_VALID cycle pops one expected byte.
  always @(negedge clk) begin
    if (val_a) begin
      vcnt_a++;
      if (exp_a.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL a_unexpected_valid: got data %0h expected no pulse", data_a);
      end else begin
        check("a_valid_data", 32'(data_a), 32'(exp_a.pop_front()));
        check("a_valid_perr", 32'(perr_a), 0);
        check("a_valid_ferr", 32'(ferr_a), 0);
      end
    end
    if (val_b) begin
      vcnt_b++;
      if (exp_b.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b_unexpected_valid: got data %0h expected no pulse", data_b);
      end else begin
        check("b_valid_data", 32'(data_b), 32'(exp_b.pop_front()));
        check("b_valid_perr", 32'(perr_b), 0);
        check("b_valid_ferr", 32'(ferr_b), 0);
      end
    end
  end

  task automatic drive(input bit sel, input logic v);
    if (sel) rxd_b = v;
    else     rxd_a = v;
  endtask

  // abort_mode: 0 = full frame, 1 = drop Rx_EN in data bit 4, 2 = reset in data bit 4
  task automatic send_frame(input bit sel, input logic [7:0] d, input logic par,
                            input logic stop, input int abort_mode);
    logic [10:0] f;
    int bt;
    f  = {stop, par, d, 1'b0};
    bt = sel ? BT_B : BT_A;
    for (int i = 0; i < 11; i++) begin
      drive(sel, f[i]);
      if (abort_mode != 0 && i == 5) begin
        repeat (bt / 2) @(negedge clk);
        if (abort_mode == 1) Rx_EN = 1'b0;
        else                 reset = 1'b0;
        repeat (2) @(negedge clk);
        drive(sel, 1'b1);
        repeat (3) @(negedge clk);
        Rx_EN = 1'b1;
        reset = 1'b1;
        repeat (bt) @(negedge clk);
        return;
      end
      repeat (bt) @(negedge clk);
    end
  endtask

  task automatic push_a(input logic [7:0] d);
    exp_a.push_back(d);
    exp_cnt_a++;
  endtask

  task automatic check_a(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    check({tag, "_data"}, 32'(data_a), 32'(d));
    check({tag, "_perr"}, 32'(perr_a), 32'(pe));
    check({tag, "_ferr"}, 32'(ferr_a), 32'(fe));
    check({tag, "_vcnt"}, 32'(vcnt_a), 32'(exp_cnt_a));
  endtask

  initial begin
    reset  = 1'b0;
    Rx_EN  = 1'b1;
    baud_a = 3'b111;
    baud_b = 3'b011;
    rxd_a  = 1'b1;
    rxd_b  = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_data", 32'(data_a), 0);
    check("rst_valid", 32'(val_a), 0);
    check("rst_perr", 32'(perr_a), 0);
    check("rst_ferr", 32'(ferr_a), 0);
    reset = 1'b1;
    repeat (BT_A) @(negedge clk);

    // Good frame.
    push_a(8'hA5);
    send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 0);
    check_a("a5", 8'hA5, 1'b0, 1'b0);

    // Wrong parity: data still loaded, no pulse.
    send_frame(1'b0, 8'h01, 1'b0, 1'b1, 0);
    check_a("par_err", 8'h01, 1'b1, 1'b0);

    // Stop bit low, then idle high before the next good frame.
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 0);
    check_a("frm_err", 8'h3C, 1'b0, 1'b1);
    drive(1'b0, 1'b1);
    repeat (BT_A) @(negedge clk);
    push_a(8'h55);
    send_frame(1'b0, 8'h55, 1'b0, 1'b1, 0);
    check_a("after_err", 8'h55, 1'b0, 1'b0);

    // Three-clock glitch is a false start.
    drive(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    drive(1'b0, 1'b1);
    repeat (2 * BT_A) @(negedge clk);
    check_a("glitch", 8'h55, 1'b0, 1'b0);

    // Enable dropped mid-frame, then a clean frame.
    send_frame(1'b0, 8'h96, 1'b1, 1'b1, 1);
    check_a("en_abort", 8'h55, 1'b0, 1'b0);
    push_a(8'h5A);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b1, 0);
    check_a("en_resume", 8'h5A, 1'b0, 1'b0);

    // Reset mid-frame, then a clean frame.
    send_frame(1'b0, 8'h96, 1'b1, 1'b1, 2);
    check_a("rst_abort", 8'h00, 1'b0, 1'b0);
    push_a(8'h5A);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b1, 0);
    check_a("rst_resume", 8'h5A, 1'b0, 1'b0);

    // Back-to-back frames on instance B at 9600 baud.
    exp_b.push_back(8'h00);
    exp_b.push_back(8'hFF);
    send_frame(1'b1, 8'h00, 1'b0, 1'b1, 0);
    send_frame(1'b1, 8'hFF, 1'b0, 1'b1, 0);
    repeat (BT_B) @(negedge clk);
    check("b2b_vcnt", 32'(vcnt_b), 2);
    check("b2b_last_data", 32'(data_b), 32'hFF);

    check("a_queue_drained", 32'(exp_a.size()), 0);
    check("b_queue_drained", 32'(exp_b.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
